// File: rtl/custom_instr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency custom-instruction unit between
// NUM_REQ requesters; a tag pipeline routes each result back to its issuer.
module custom_instr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int HID_WIDTH = 1,
    parameter int LATENCY   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic [NUM_REQ*HID_WIDTH-1:0]   req_hid_in,
    input  logic [NUM_REQ*5-1:0]           req_major_opcode_in,
    input  logic [NUM_REQ*3-1:0]           req_minor_opcode_in,
    input  logic [NUM_REQ*32-1:0]          req_op1_in,
    input  logic [NUM_REQ*32-1:0]          req_op2_in,
    input  logic [NUM_REQ*32-1:0]          req_imm_in,
    input  logic [NUM_REQ*7-1:0]           req_funct7_in,
    output logic [NUM_REQ-1:0]             rsp_valid_out,
    output logic [31:0]                    rsp_result_out,
    output logic                           unit_valid_out,
    output logic [HID_WIDTH-1:0]           unit_hid_out,
    output logic [4:0]                     unit_major_opcode_out,
    output logic [2:0]                     unit_minor_opcode_out,
    output logic [31:0]                    unit_op1_out,
    output logic [31:0]                    unit_op2_out,
    output logic [31:0]                    unit_imm_out,
    output logic [6:0]                     unit_funct7_out,
    input  logic [31:0]                    unit_result_in
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            busy_q, busy_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LATENCY:0]              tag_vld_q;
    logic [LATENCY:0][IDX_W-1:0]   tag_idx_q;
    logic [NUM_REQ-1:0]            rsp_valid_q;
    logic [31:0]                   rsp_result_q;
    logic                          unit_valid_q;
    logic [HID_WIDTH-1:0]          unit_hid_q;
    logic [4:0]                    unit_major_q;
    logic [2:0]                    unit_minor_q;
    logic [31:0]                   unit_op1_q, unit_op2_q, unit_imm_q;
    logic [6:0]                    unit_funct7_q;

    logic [NUM_REQ-1:0]            elig;
    logic                          gnt_found;
    logic [IDX_W-1:0]              gnt_idx;
    logic [IDX_W-1:0]              cand_idx;
    int                            cand;

    // Search the eligible set starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        elig      = req_valid_in & ~busy_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_found && elig[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        if (rst) gnt_found = 1'b0;
    end

    always_comb begin
        req_ready_out = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
        busy_d        = (busy_q | req_ready_out) & ~rsp_valid_q;
        rr_ptr_d      = rr_ptr_q;
        if (gnt_found)
            rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            tag_vld_q     <= '0;
            tag_idx_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            unit_valid_q  <= 1'b0;
            unit_hid_q    <= '0;
            unit_major_q  <= '0;
            unit_minor_q  <= '0;
            unit_op1_q    <= '0;
            unit_op2_q    <= '0;
            unit_imm_q    <= '0;
            unit_funct7_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            unit_valid_q <= gnt_found;
            tag_vld_q    <= {tag_vld_q[LATENCY-1:0], gnt_found};
            tag_idx_q    <= {tag_idx_q[LATENCY-1:0], gnt_idx};
            if (gnt_found) begin
                unit_hid_q    <= req_hid_in[gnt_idx*HID_WIDTH +: HID_WIDTH];
                unit_major_q  <= req_major_opcode_in[gnt_idx*5 +: 5];
                unit_minor_q  <= req_minor_opcode_in[gnt_idx*3 +: 3];
                unit_op1_q    <= req_op1_in[gnt_idx*32 +: 32];
                unit_op2_q    <= req_op2_in[gnt_idx*32 +: 32];
                unit_imm_q    <= req_imm_in[gnt_idx*32 +: 32];
                unit_funct7_q <= req_funct7_in[gnt_idx*7 +: 7];
            end
            // The tag at the last stage marks the cycle the unit result is valid.
            rsp_valid_q <= tag_vld_q[LATENCY] ? (NUM_REQ'(1) << tag_idx_q[LATENCY]) : '0;
            if (tag_vld_q[LATENCY]) rsp_result_q <= unit_result_in;
        end
    end

    assign rsp_valid_out         = rsp_valid_q;
    assign rsp_result_out        = rsp_result_q;
    assign unit_valid_out        = unit_valid_q;
    assign unit_hid_out          = unit_hid_q;
    assign unit_major_opcode_out = unit_major_q;
    assign unit_minor_opcode_out = unit_minor_q;
    assign unit_op1_out          = unit_op1_q;
    assign unit_op2_out          = unit_op2_q;
    assign unit_imm_out          = unit_imm_q;
    assign unit_funct7_out       = unit_funct7_q;
endmodule

// File: tb/tb_custom_instr_arbiter.sv
// Bench for custom_instr_arbiter: a 2-requester/latency-1 instance driven by a
// cycle table, a fairness run and random traffic, plus a 4-requester/latency-4 instance.
module tb_custom_instr_arbiter;
    localparam int NA = 2, LA = 1, NB = 4, LB = 4;

    logic clk, rst;
    int   n_cmp = 0, n_bad = 0;

    // ---------------- instance A (NUM_REQ=2, LATENCY=1) ----------------
    logic [NA-1:0]        a_v, a_rdy, a_rv, a_hid;
    logic [NA-1:0][4:0]   a_maj;
    logic [NA-1:0][2:0]   a_min;
    logic [NA-1:0][31:0]  a_op1, a_op2, a_imm;
    logic [NA-1:0][6:0]   a_f7;
    logic [31:0]          a_rres, a_ures;
    logic                 a_uv, a_uhid;
    logic [4:0]           a_umaj;
    logic [2:0]           a_umin;
    logic [31:0]          a_uop1, a_uop2, a_uimm;
    logic [6:0]           a_uf7;

    custom_instr_arbiter #(.NUM_REQ(NA), .HID_WIDTH(1), .LATENCY(LA)) u_a (
        .clk(clk), .rst(rst), .req_valid_in(a_v), .req_ready_out(a_rdy),
        .req_hid_in(a_hid), .req_major_opcode_in(a_maj), .req_minor_opcode_in(a_min),
        .req_op1_in(a_op1), .req_op2_in(a_op2), .req_imm_in(a_imm), .req_funct7_in(a_f7),
        .rsp_valid_out(a_rv), .rsp_result_out(a_rres),
        .unit_valid_out(a_uv), .unit_hid_out(a_uhid), .unit_major_opcode_out(a_umaj),
        .unit_minor_opcode_out(a_umin), .unit_op1_out(a_uop1), .unit_op2_out(a_uop2),
        .unit_imm_out(a_uimm), .unit_funct7_out(a_uf7), .unit_result_in(a_ures));

    // ---------------- instance B (NUM_REQ=4, LATENCY=4) ----------------
    logic [NB-1:0]        b_v, b_rdy, b_rv, b_hid;
    logic [NB-1:0][4:0]   b_maj;
    logic [NB-1:0][2:0]   b_min;
    logic [NB-1:0][31:0]  b_op1, b_op2, b_imm;
    logic [NB-1:0][6:0]   b_f7;
    logic [31:0]          b_rres, b_ures;
    logic                 b_uv, b_uhid;
    logic [4:0]           b_umaj;
    logic [2:0]           b_umin;
    logic [31:0]          b_uop1, b_uop2, b_uimm;
    logic [6:0]           b_uf7;

    custom_instr_arbiter #(.NUM_REQ(NB), .HID_WIDTH(1), .LATENCY(LB)) u_b (
        .clk(clk), .rst(rst), .req_valid_in(b_v), .req_ready_out(b_rdy),
        .req_hid_in(b_hid), .req_major_opcode_in(b_maj), .req_minor_opcode_in(b_min),
        .req_op1_in(b_op1), .req_op2_in(b_op2), .req_imm_in(b_imm), .req_funct7_in(b_f7),
        .rsp_valid_out(b_rv), .rsp_result_out(b_rres),
        .unit_valid_out(b_uv), .unit_hid_out(b_uhid), .unit_major_opcode_out(b_umaj),
        .unit_minor_opcode_out(b_umin), .unit_op1_out(b_uop1), .unit_op2_out(b_uop2),
        .unit_imm_out(b_uimm), .unit_funct7_out(b_uf7), .unit_result_in(b_ures));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared-unit models: result = op1 + op2 after the unit latency; random junk otherwise.
    logic [31:0]   ua_r [LA];
    logic [LA-1:0] ua_v;
    logic [31:0]   ub_r [LB];
    logic [LB-1:0] ub_v;
    logic [31:0]   junk;
    always @(posedge clk) begin
        for (int k = LA - 1; k > 0; k--) begin ua_r[k] <= ua_r[k-1]; ua_v[k] <= ua_v[k-1]; end
        for (int k = LB - 1; k > 0; k--) begin ub_r[k] <= ub_r[k-1]; ub_v[k] <= ub_v[k-1]; end
        ua_r[0] <= a_uop1 + a_uop2;  ua_v[0] <= a_uv;
        ub_r[0] <= b_uop1 + b_uop2;  ub_v[0] <= b_uv;
        junk    <= $urandom;
    end
    assign a_ures = (ua_v[LA-1] === 1'b1) ? ua_r[LA-1] : junk;
    assign b_ures = (ub_v[LB-1] === 1'b1) ? ub_r[LB-1] : junk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [111:0] pack_a(input int i);
        return {a_hid[i], a_maj[i], a_min[i], a_op1[i], a_op2[i], a_imm[i], a_f7[i]};
    endfunction
    function automatic logic [111:0] upack_a();
        return {a_uhid, a_umaj, a_umin, a_uop1, a_uop2, a_uimm, a_uf7};
    endfunction

    // Reference model for A: timing expressed as cycle arithmetic from the rules.
    typedef struct { int due; int idx; logic [31:0] res; } pend_t;
    pend_t          pend[$];
    int             cyc = 0, ptr = 0, last_g = -1;
    int             free_at [NA];
    bit             prev_rst = 1'b1, exp_uv = 1'b0;
    logic [111:0]   exp_f = '0;

    task automatic model();
        logic [NA-1:0] er, erv;
        logic [31:0]   eres;
        pend_t         p;
        int            g, idx;
        erv = '0; eres = '0;
        if (prev_rst) begin
            chk("a_rst_unit_valid", a_uv, 0);
            chk("a_rst_rsp_valid", a_rv, 0);
            chk("a_rst_rsp_result", a_rres, 0);
            chk("a_rst_unit_fields", upack_a(), 0);
        end else begin
            chk("a_unit_valid", a_uv, exp_uv);
            if (exp_uv) chk("a_unit_fields", upack_a(), exp_f);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                erv[pend[0].idx] = 1'b1;
                eres = pend[0].res;
                void'(pend.pop_front());
            end
            chk("a_rsp_valid", a_rv, erv);
            if (erv != 0) chk("a_rsp_result", a_rres, eres);
        end
        g = -1; er = '0;
        if (!rst)
            for (int k = 0; k < NA; k++) begin
                idx = (ptr + k) % NA;
                if (g < 0 && a_v[idx] && cyc >= free_at[idx]) g = idx;
            end
        if (g >= 0) er[g] = 1'b1;
        chk("a_ready", a_rdy, er);
        last_g = g;
        if (rst) begin
            ptr = 0; pend.delete(); exp_uv = 1'b0; exp_f = '0; prev_rst = 1'b1;
            foreach (free_at[i]) free_at[i] = 0;
        end else begin
            prev_rst = 1'b0;
            exp_uv   = (g >= 0);
            if (g >= 0) begin
                exp_f      = pack_a(g);
                free_at[g] = cyc + LA + 3;
                p.due = cyc + LA + 2; p.idx = g; p.res = a_op1[g] + a_op2[g];
                pend.push_back(p);
                ptr = (g + 1) % NA;
            end
        end
        cyc++;
    endtask

    task automatic at_neg();
        @(negedge clk);
        model();
    endtask
    task automatic to_next();
        @(posedge clk);
        #1;
    endtask
    task automatic rand_req(input int i);
        a_hid[i] = 1'($urandom); a_maj[i] = 5'($urandom); a_min[i] = 3'($urandom);
        a_op1[i] = $urandom; a_op2[i] = $urandom; a_imm[i] = $urandom; a_f7[i] = 7'($urandom);
    endtask

    typedef struct {
        bit          rst;
        logic [1:0]  v;
        logic [31:0] op0, op1;
        logic [1:0]  rdy;
        bit          uv;
        logic [1:0]  rv;
        logic [31:0] res;
    } vec_t;
    vec_t tbl [28];

    initial begin
        int g, prev_g, cnt0, cnt1, alt_bad;
        logic [3:0] e4;

        for (int i = 0; i < 28; i++) tbl[i] = '{0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 2'b00, 32'h0};
        // single request -> result 0xdeadbeef three cycles later
        tbl[0].rst = 1;
        tbl[1].v = 2'b01; tbl[1].op0 = 32'h1234_5678; tbl[1].rdy = 2'b01;
        tbl[2].uv = 1;
        tbl[4].rv = 2'b01; tbl[4].res = 32'hdead_beef;
        // simultaneous valids after reset
        tbl[5].rst = 1;
        tbl[6].v = 2'b11; tbl[6].op0 = 32'h1000_0001; tbl[6].op1 = 32'h2000_0002; tbl[6].rdy = 2'b01;
        tbl[7].v = 2'b10; tbl[7].op1 = 32'h2000_0002; tbl[7].rdy = 2'b10; tbl[7].uv = 1;
        tbl[8].uv = 1;
        tbl[9].rv = 2'b01;  tbl[9].res = 32'hdc79_6878;
        tbl[10].rv = 2'b10; tbl[10].res = 32'h2000_0002;
        // outstanding limit: requester 1 re-asserts right after acceptance
        tbl[11].v = 2'b10; tbl[11].op1 = 32'h3000_0003; tbl[11].rdy = 2'b10;
        for (int i = 12; i <= 15; i++) begin tbl[i].v = 2'b10; tbl[i].op1 = 32'h3000_0004; end
        tbl[12].uv = 1;
        tbl[14].rv = 2'b10; tbl[14].res = 32'h3000_0003;
        tbl[15].rdy = 2'b10;
        tbl[16].uv = 1;
        tbl[18].rv = 2'b10; tbl[18].res = 32'h3000_0004;
        // reset mid-flight, then a fresh request
        tbl[19].v = 2'b01; tbl[19].op0 = 32'h4000_0000; tbl[19].rdy = 2'b01;
        tbl[20].rst = 1; tbl[20].uv = 1;
        tbl[23].v = 2'b01; tbl[23].op0 = 32'h0000_0005; tbl[23].rdy = 2'b01;
        tbl[24].uv = 1;
        tbl[26].rv = 2'b01; tbl[26].res = 32'hcc79_687c;

        rst = 1'b1; a_v = '0; b_v = '0;
        a_hid = 2'b10; a_maj = {5'h02, 5'h02}; a_min = '0;
        a_op1 = '0; a_op2 = {32'h0, 32'hcc79_6877};
        a_imm = {32'h0000_0bbb, 32'h0000_0aaa}; a_f7 = {7'h22, 7'h11};
        b_hid = 4'b1010; b_maj = '0; b_min = '0; b_imm = '0; b_f7 = '0;
        b_op1 = {32'h40, 32'h30, 32'h20, 32'h10};
        b_op2 = {32'h1, 32'h1, 32'h1, 32'h1};
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 28; r++) begin
            rst = tbl[r].rst; a_v = tbl[r].v;
            a_op1[0] = tbl[r].op0; a_op1[1] = tbl[r].op1;
            at_neg();
            chk($sformatf("tbl%0d_ready", r), a_rdy, tbl[r].rdy);
            chk($sformatf("tbl%0d_unit_valid", r), a_uv, tbl[r].uv);
            chk($sformatf("tbl%0d_rsp_valid", r), a_rv, tbl[r].rv);
            if (tbl[r].rv != 0) chk($sformatf("tbl%0d_rsp_result", r), a_rres, tbl[r].res);
            to_next();
        end

        // fairness: both held valid for 40 cycles after reset
        rst = 1'b1; a_v = '0;
        at_neg(); to_next();
        rst = 1'b0; a_v = 2'b11;
        cnt0 = 0; cnt1 = 0; prev_g = -1; alt_bad = 0;
        for (int c = 0; c < 40; c++) begin
            at_neg();
            g = last_g;
            if (g == 0) cnt0++;
            if (g == 1) cnt1++;
            if (g >= 0 && prev_g >= 0 && g == prev_g) alt_bad++;
            if (g >= 0) prev_g = g;
            to_next();
            if (g >= 0) rand_req(g);
        end
        chk("fair_grants_req0", cnt0, 10);
        chk("fair_grants_req1", cnt1, 10);
        chk("fair_alternation_breaks", alt_bad, 0);

        // random traffic with occasional resets
        a_v = '0;
        for (int c = 0; c < 400; c++) begin
            at_neg();
            g = last_g;
            to_next();
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NA; i++) begin
                if (g == i) begin
                    rand_req(i); a_v[i] = 1'($urandom);
                end else if (a_v[i]) begin
                    if ($urandom_range(0, 7) == 0) a_v[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    rand_req(i); a_v[i] = 1'b1;
                end
            end
        end

        // instance B: four simultaneous requests, latency 4
        rst = 1'b1; a_v = '0;
        at_neg(); to_next();
        rst = 1'b0; b_v = 4'hf;
        for (int t = 0; t < 12; t++) begin
            at_neg();
            e4 = (t < 4) ? (4'(1) << t) : 4'h0;
            chk($sformatf("b_ready_t%0d", t), b_rdy, e4);
            chk($sformatf("b_unit_valid_t%0d", t), b_uv, (t >= 1 && t <= 4));
            if (t >= 1 && t <= 4) chk($sformatf("b_unit_op1_t%0d", t), b_uop1, 32'h10 * t);
            e4 = (t >= 6 && t <= 9) ? (4'(1) << (t - 6)) : 4'h0;
            chk($sformatf("b_rsp_valid_t%0d", t), b_rv, e4);
            if (e4 != 0) chk($sformatf("b_rsp_result_t%0d", t), b_rres, 32'h10 * (t - 5) + 1);
            to_next();
            if (t < 4) b_v[t] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/custom_instr_arbiter.md
# custom_instr_arbiter

Round-robin arbiter that shares one pipelined custom-instruction execution unit between `NUM_REQ` requesters, such as several RISC-V cores or hart groups each exporting a custom-instruction port. It grants at most one request per cycle and drives the shared unit's custom-instruction interface with registered outputs. It tracks which requester owns each in-flight operation and returns the unit's result to that requester after the unit's fixed latency. Each requester may have at most one outstanding operation.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `HID_WIDTH`, default 1: hart-id width.
- `LATENCY`, default 1: cycles from `unit_valid_out` to valid `unit_result_in`, 1..8.

Ports:
- `clk`  in  1  clock; the block uses this single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_in`  in  NUM_REQ  per-requester request valid.
- `req_ready_out`  out  NUM_REQ  per-requester grant; a request is accepted when valid and ready are both high.
- `req_hid_in`  in  NUM_REQ*HID_WIDTH  hart id, packed with requester i at bits [i*HID_WIDTH +: HID_WIDTH].
- `req_major_opcode_in`  in  NUM_REQ*5  major opcode.
- `req_minor_opcode_in`  in  NUM_REQ*3  minor opcode.
- `req_op1_in`, `req_op2_in`, `req_imm_in`  in  NUM_REQ*32 each  operands.
- `req_funct7_in`  in  NUM_REQ*7  funct7.
- `rsp_valid_out`  out  NUM_REQ  one-cycle result strobe.
- `rsp_result_out`  out  32  result; meaningful only while some `rsp_valid_out` bit is high.
- `unit_valid_out`, `unit_hid_out`, `unit_major_opcode_out`, `unit_minor_opcode_out`, `unit_op1_out`, `unit_op2_out`, `unit_imm_out`, `unit_funct7_out`  out  widths as above  shared-unit issue port.
- `unit_result_in`  in  32  shared-unit result.

## Operation
Per-requester state:
- `busy[i]` is set on acceptance and cleared in the cycle `rsp_valid_out[i]` is asserted.

Arbitration (combinational, each cycle):
- Eligible set = `req_valid_in & ~busy`.
- Search starts at pointer `rr_ptr` and increments modulo `NUM_REQ`; the first eligible requester g is granted.
- `req_ready_out[g]` = 1; all other bits are 0. `req_ready_out` may depend combinationally on `req_valid_in`.
- With no eligible requester, `req_ready_out` = 0.

On grant:
- Register requester g's fields onto the unit outputs.
- `unit_valid_out` = 1 in the next cycle.
- `busy[g]` is set.
- `rr_ptr` becomes (g+1) mod `NUM_REQ`.

Without a grant:
- `unit_valid_out` = 0 in the next cycle.
- The unit data outputs hold their previous values.

Ownership tracking:
- A shift pipeline of depth `LATENCY`+1 carries {valid, requester index} alongside each issued operation.
- When the tag reaches the result stage, `unit_result_in` is registered into `rsp_result_out` and `rsp_valid_out[index]` is pulsed for one cycle.
- `unit_result_in` is ignored in cycles with no valid tag at the result stage.

Arithmetic and overlap:
- The block performs no arithmetic on operands; fields pass through bit-exact.
- Back-to-back grants to different requesters are allowed, so one op can be issued every cycle.
- Responses leave in issue order, at most one per cycle, so `rsp_valid_out` is one-hot or zero.

Reset:
- All outputs are 0 in the cycle after `rst` is sampled high: `req_ready_out`, `rsp_valid_out`, `rsp_result_out`, `unit_valid_out`, and every `unit_*` data output.
- `busy` is cleared, the tag pipeline is cleared, and `rr_ptr` = 0.
- While `rst` is high, `req_ready_out` = 0.
- Reset mid-operation discards every in-flight operation: no `rsp_valid_out` is issued for it, and any `unit_result_in` returned later is ignored.

## Timing
- Request accepted in cycle T: `unit_valid_out` is high in T+1 and `unit_result_in` is sampled in T+1+LATENCY.
- `rsp_valid_out[g]` and `rsp_result_out` are high in T+2+LATENCY. `busy[g]` clears at the end of that cycle.
- Requester g can be granted again in T+3+LATENCY at the earliest. Its round-trip issue interval is therefore LATENCY+3 cycles.
- Simultaneous valids: the requester nearest at-or-after `rr_ptr` wins; the losers stay valid and must hold their fields stable.
- A requester dropping valid before being granted is permitted; nothing is issued for it.

## Test plan
- **Single request, LATENCY=1.** Requester 0 sends major=0x02, minor=0, op1=0x12345678; the unit model returns 0xdeadbeef.
  - Response: `unit_valid_out` at T+1 with op1 0x12345678, and `rsp_valid_out`=2'b01 with result 0xdeadbeef at T+3.
- **Simultaneous valids after reset.** Both requesters valid in cycle T.
  - Response: requester 0 is granted at T and requester 1 at T+1. `unit_valid_out` is high at T+1 and T+2. Responses arrive at T+3 (bit 0) and T+4 (bit 1).
- **Fairness.** Both requesters held continuously valid for 40 cycles.
  - Response: grants alternate 0,1,0,1. Each requester completes 10 ops, one per 4 cycles (LATENCY+3 with LATENCY=1), and grant counts never differ by more than 1.
- **Outstanding limit.** Requester 1 is re-asserted valid immediately after acceptance at T.
  - Response: `req_ready_out[1]` stays 0 through T+3, and the second grant occurs at T+4.
- **LATENCY=4, NUM_REQ=4.** Requesters 0–3 send op1=0x10,0x20,0x30,0x40; the model returns op1+1.
  - Response: results 0x11,0x21,0x31,0x41 appear at T+6..T+9 on the matching `rsp_valid_out` bits.
- **Reset mid-flight.** `rst` is pulsed for 1 cycle at T+1 after an acceptance at T.
  - Response: no `rsp_valid_out` ever follows, and all outputs are 0 at T+2. A fresh request after reset completes normally.
